// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: control status codes, sample dumper
// state encodings and sample memory select constants.
package iagc_pkg;

    typedef enum logic [3:0] {
        IAGC_RESET    = 4'd0,
        IAGC_INIT     = 4'd1,
        IAGC_IDLE     = 4'd2,
        IAGC_CAPTURE  = 4'd3,
        IAGC_DUMP_REF = 4'd4,
        IAGC_DUMP_ERR = 4'd5,
        IAGC_RUN      = 4'd6,
        IAGC_HALT     = 4'd7
    } iagc_status_t;

    localparam logic [2:0] DMP_IDLE    = 3'd0;
    localparam logic [2:0] DMP_FETCH   = 3'd1;
    localparam logic [2:0] DMP_LATCH   = 3'd2;
    localparam logic [2:0] DMP_SEND_HI = 3'd3;
    localparam logic [2:0] DMP_SEND_LO = 3'd4;
    localparam logic [2:0] DMP_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = DMP_IDLE,
        S_FETCH   = DMP_FETCH,
        S_LATCH   = DMP_LATCH,
        S_SEND_HI = DMP_SEND_HI,
        S_SEND_LO = DMP_SEND_LO,
        S_DONE    = DMP_DONE
    } dumper_state_t;

    localparam logic MEM_SEL_REF = 1'b0;
    localparam logic MEM_SEL_ERR = 1'b1;

endpackage

// File: rtl/sample_dumper_if.sv
// Byte stream handshake from the sample dumper to the UART
// transmitter: data/valid forward, ready backward.
interface sample_dumper_if #(
    parameter int BYTE_SIZE = 8
) ();

    logic [BYTE_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/sample_dumper.sv
// Streams captured samples from the reference or error memory to
// the UART transmitter, MSB byte first, one sample at a time.
module sample_dumper
    import iagc_pkg::*;
#(
    parameter int SAMPLER_DATA_SIZE = 16,
    parameter int ADDR_SIZE         = 12,
    parameter int BYTE_SIZE         = 8
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_select,
    input  logic [ADDR_SIZE-1:0]         i_memory_size,
    output logic [ADDR_SIZE-1:0]         o_addr,
    input  logic [SAMPLER_DATA_SIZE-1:0] i_reference_sample,
    input  logic [SAMPLER_DATA_SIZE-1:0] i_error_sample,
    sample_dumper_if.master              tx_if,
    output logic                         o_busy,
    output logic                         o_done
);

    dumper_state_t                r_state;
    dumper_state_t                w_next;
    logic [ADDR_SIZE-1:0]         r_addr;
    logic [ADDR_SIZE-1:0]         r_size;
    logic                         r_sel;
    logic [SAMPLER_DATA_SIZE-1:0] r_word;
    logic                         w_last;

    assign w_last = (r_addr == (r_size - ADDR_SIZE'(1)));

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_memory_size == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_FETCH:   w_next = S_LATCH;
            S_LATCH:   w_next = S_SEND_HI;
            S_SEND_HI: begin
                if (tx_if.tx_ready) begin
                    w_next = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (tx_if.tx_ready) begin
                    w_next = w_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Dump parameters, read address and the sample being sent
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_addr <= '0;
            r_size <= '0;
            r_sel  <= MEM_SEL_REF;
            r_word <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel  <= i_select;
                        r_size <= i_memory_size;
                        r_addr <= '0;
                    end
                end
                S_LATCH: begin
                    if (r_sel == MEM_SEL_ERR) begin
                        r_word <= i_error_sample;
                    end else begin
                        r_word <= i_reference_sample;
                    end
                end
                S_SEND_LO: begin
                    if (tx_if.tx_ready && !w_last) begin
                        r_addr <= r_addr + ADDR_SIZE'(1);
                    end
                end
                S_DONE: begin
                    r_addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the state register only
    always_comb begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        unique case (r_state)
            S_SEND_HI: begin
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = r_word[SAMPLER_DATA_SIZE-1 -: BYTE_SIZE];
            end
            S_SEND_LO: begin
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = r_word[BYTE_SIZE-1:0];
            end
            default: begin
            end
        endcase
    end

    assign o_addr = r_addr;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_sample_dumper.sv
// Self-checking bench for sample_dumper: table vectors, random
// dumps against a byte-queue model, restart and reset sequences.
module tb_sample_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [11:0] msize;
    logic [11:0] addr;
    logic [15:0] ref_q;
    logic [15:0] err_q;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sample_dumper_if #(.BYTE_SIZE(8)) tx_if ();

    sample_dumper #(
        .SAMPLER_DATA_SIZE(16),
        .ADDR_SIZE(12),
        .BYTE_SIZE(8)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_start(start),
        .i_select(sel),
        .i_memory_size(msize),
        .o_addr(addr),
        .i_reference_sample(ref_q),
        .i_error_sample(err_q),
        .tx_if(tx_if),
        .o_busy(busy),
        .o_done(done)
    );

    logic [15:0] ref_mem [4096];
    logic [15:0] err_mem [4096];

    always @(posedge clk) begin
        ref_q <= ref_mem[addr];
        err_q <= err_mem[addr];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 16'($urandom);
            err_mem[i] = 16'($urandom);
        end
    endtask

    typedef struct packed {
        int                 n;
        bit                 s;
        int                 mode;
        int                 nfix;
        logic [0:3][15:0]   words;
        int                 nexp;
        logic [0:7][7:0]    bytes;
        int                 exp_done;
        int                 restart_at;
    } vec_t;

    vec_t vecs [6];

    // mode: 0 ready always, 1 ready one cycle in three, 2 random
    task automatic run_dump(input int n, input bit s, input int mode,
                            input int restart_at, input bit use_tab,
                            input logic [0:7][7:0] tab_bytes,
                            input int tab_n, input int exp_done);
        logic [7:0] q[$];
        logic [15:0] w;
        logic [7:0] e;
        logic [7:0] pdata;
        bit pstall;
        bit rdy;
        int cyc, done_cyc, busy_cnt, done_cnt, nbytes, budget, total;
        q = {};
        if (use_tab) begin
            for (int i = 0; i < tab_n; i++) q.push_back(tab_bytes[i]);
        end else begin
            for (int i = 0; i < n; i++) begin
                w = s ? err_mem[i] : ref_mem[i];
                q.push_back(w[15:8]);
                q.push_back(w[7:0]);
            end
        end
        total = q.size();
        @(negedge clk);
        sel = s;
        msize = 12'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        done_cyc = -1;
        busy_cnt = 0;
        done_cnt = 0;
        nbytes = 0;
        pstall = 1'b0;
        pdata = '0;
        budget = 12 * n + 40;
        while (cyc < budget && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pstall) begin
                chk("hold_valid", 32'(tx_if.tx_valid), 32'd1);
                chk("hold_data", 32'(tx_if.tx_data), 32'(pdata));
            end
            sel = 1'($urandom);
            msize = 12'($urandom);
            start = 1'b0;
            if (restart_at >= 0 && (cyc == restart_at || done)) begin
                start = 1'b1;
                msize = 12'd1;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom);
            endcase
            tx_if.tx_ready = rdy;
            if (tx_if.tx_valid && rdy) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("byte", 32'(tx_if.tx_data), 32'(e));
                    chk("addr", 32'(addr), 32'(nbytes / 2));
                end
                nbytes++;
            end
            pstall = tx_if.tx_valid && !rdy;
            pdata = tx_if.tx_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tx_if.tx_ready = 1'b0;
        chk("byte_count", 32'(nbytes), 32'(total));
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(done_cyc + 1));
        if (exp_done >= 0) chk("done_cycle", 32'(done_cyc), 32'(exp_done));
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{n: 4, s: 1'b0, mode: 0, nfix: 4,
                    words: {16'h1234, 16'hFFEE, 16'h0001, 16'h8000},
                    nexp: 8,
                    bytes: {8'h12, 8'h34, 8'hFF, 8'hEE,
                            8'h00, 8'h01, 8'h80, 8'h00},
                    exp_done: 16, restart_at: -1};
        vecs[1] = '{n: 2, s: 1'b1, mode: 1, nfix: 2,
                    words: {16'hABCD, 16'h0F0F, 16'h0, 16'h0},
                    nexp: 4,
                    bytes: {8'hAB, 8'hCD, 8'h0F, 8'h0F,
                            8'h0, 8'h0, 8'h0, 8'h0},
                    exp_done: -1, restart_at: -1};
        vecs[2] = '{n: 0, s: 1'b0, mode: 0, nfix: 0, words: '0,
                    nexp: 0, bytes: '0, exp_done: 0, restart_at: -1};
        vecs[3] = '{n: 1, s: 1'b1, mode: 0, nfix: 0, words: '0,
                    nexp: -1, bytes: '0, exp_done: 4, restart_at: -1};
        vecs[4] = '{n: 7, s: 1'b0, mode: 2, nfix: 0, words: '0,
                    nexp: -1, bytes: '0, exp_done: -1, restart_at: -1};
        vecs[5] = '{n: 3, s: 1'b0, mode: 0, nfix: 0, words: '0,
                    nexp: -1, bytes: '0, exp_done: 12, restart_at: 5};

        rst = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        msize = '0;
        tx_if.tx_ready = 1'b0;
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("rst_data", 32'(tx_if.tx_data), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            fill_random();
            for (int i = 0; i < vecs[v].nfix; i++) begin
                if (vecs[v].s) err_mem[i] = vecs[v].words[i];
                else ref_mem[i] = vecs[v].words[i];
            end
            run_dump(vecs[v].n, vecs[v].s, vecs[v].mode,
                     vecs[v].restart_at, vecs[v].nexp >= 0,
                     vecs[v].bytes, vecs[v].nexp, vecs[v].exp_done);
        end

        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_dump($urandom_range(1, 20), 1'($urandom), 2, -1,
                     1'b0, '0, 0, -1);
        end

        fill_random();
        @(negedge clk);
        sel = 1'b0;
        msize = 12'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tx_if.tx_ready = 1'b1;
        repeat (7) @(negedge clk);
        chk("pre_rst_valid", 32'(tx_if.tx_valid), 32'd1);
        chk("pre_rst_lo", 32'(tx_if.tx_data), 32'(ref_mem[1][7:0]));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(tx_if.tx_valid), 32'd0);
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tx_if.tx_ready = 1'b0;
        run_dump(3, 1'b0, 0, -1, 1'b0, '0, 0, 12);

        fill_random();
        run_dump(4095, 1'b1, 0, -1, 1'b0, '0, 0, 16380);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
